reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
// - Architectural register file plus rename-tag table, directly downstream of the reorder buffer.
// - Consumes ROB commits (dest, rd, value) and retires values into x1..x31.
// - Serves the issuer: per source operand, either a committed value or the ROB tag of the pending producer.
// - Records the issuer's rename of rd to a newly allocated ROB entry.
// PARAMETERS
// - XLEN      32  register data width (matches REG_TYPE)
// - REG_NUM   32  architectural registers; x0 hardwired to 0
// - ROB_ID_W  4   ROB tag width; tag 0 = "no producer", valid tags 1..15
// PORTS
// - clk               in   1         clock
// - rst               in   1         synchronous, active-high reset
// - rdy               in   1         global enable; low = hold all state
// - reset_from_rob_bus in  1         mispredict flush from ROB
// - rs1_from_issuer   in   5         source 1 index
// - rs2_from_issuer   in   5         source 2 index
// - qj_to_issuer      out  ROB_ID_W  tag for rs1 (0 = value ready)
// - vj_to_issuer      out  XLEN      committed value of rs1
// - qk_to_issuer      out  ROB_ID_W  tag for rs2
// - vk_to_issuer      out  XLEN      committed value of rs2
// - valid_from_issuer in   1         rename request this cycle
// - rd_from_issuer    in   5         destination being renamed
// - dest_from_issuer  in   ROB_ID_W  ROB entry allocated to rd
// - dest_from_rob     in   ROB_ID_W  committing ROB entry (0 = no commit)
// - rd_from_rob       in   5         committing destination
// - value_from_rob    in   XLEN      committing value
// BEHAVIOUR
// - State: value[1..31] (XLEN), tag[1..31] (ROB_ID_W). Register index 0 has no storage.
// - Reset (rst=1 at posedge): all values = 0, all tags = 0. Takes priority over rdy and all other inputs.
//   Combinational outputs therefore read 0/0 after reset.
// - rdy=0: no state update. Outputs still reflect the current state.
// - Read (combinational):
//   - rsX==0 -> q=0, v=0.
//   - Otherwise q=tag[rsX], v=value[rsX]. When q!=0, v is stale; the issuer must use the ROB for it.
// - Commit (posedge, dest_from_rob!=0, rd_from_rob!=0):
//   - value[rd] <= value_from_rob.
//   - tag[rd] <= 0 only if tag[rd]==dest_from_rob. A younger rename keeps its tag.
// - Commit with rd_from_rob==0 (stores, branches without rd): no write.
// - Rename (posedge, valid_from_issuer=1, rd_from_issuer!=0): tag[rd] <= dest_from_issuer.
//   rd==0 is ignored.
// - Same cycle, same rd, commit + rename: value is written, and tag = dest_from_issuer (rename wins).
// - Same cycle, same rd, commit whose tag matches + rename: the rename tag still wins.
// - Flush (reset_from_rob_bus=1 at posedge):
//   - All tags <= 0.
//   - The same-cycle commit value IS written.
//   - The same-cycle rename is dropped.
//   - Values are otherwise preserved.
// - Latency: a commit/rename is visible on read outputs the cycle after its posedge (without bypass).
// - Tag wrap: ROB tags wrap 15->1. A stale equal tag is impossible, since ROB occupancy < 15 and a
//   matching tag always belongs to the live producer.
// CONFIGURATION
// - REG_FILE_COMMIT_BYPASS_EN defined:
//   - If rsX!=0, rsX==rd_from_rob, dest_from_rob!=0, and tag[rsX]==dest_from_rob, then
//     q=0 and v=value_from_rob in the same cycle (commit forwarding).
//   - Gated by rdy=1 and rst=0.
// - Undefined: no forwarding; the issuer sees the commit one cycle later.
// TESTING
// - Reset, then read rs1=5, rs2=0 -> qj=0, vj=0, qk=0, vk=0.
// - Rename x5->tag 3, then commit dest=3, rd=5, value=0xDEADBEEF -> after 2 cycles qj=0, vj=0xDEADBEEF.
// - Rename x7->tag 2, rename x7->tag 4, then commit dest=2, rd=7, value=0x11 -> qj=4, vj=0x11 (tag kept).
// - Same cycle: commit dest=6, rd=9, value=0x22, and rename x9->tag 8 -> next cycle q=8, v=0x22.
// - Tags on x1 and x2 pending, then reset_from_rob_bus with commit dest=1, rd=1, value=0x33 and rename x3->tag 5
//   -> q1=q2=q3=0, v1=0x33.
// - rdy=0 with rename x4->tag 6 -> tag[4] unchanged.
// - Bypass build: rs1=10, tag[10]=9, commit dest=9, rd=10, value=0x44 -> same cycle qj=0, vj=0x44.
// - Non-bypass build, same stimulus -> qj=9.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: architectural register file plus rename-tag table, downstream of the ROB.
//
// Keeps the committed value and the pending-producer ROB tag for x1..x31. x0 has no
// storage and always reads as value 0 with tag 0. Tag 0 means "no producer pending".
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (beats rdy and all else)
//   rdy                  global enable; low holds all state
//   reset_from_rob_bus   mispredict flush: clears every tag, drops the same-cycle rename
//   rs1/rs2_from_issuer  source indices; qj/vj and qk/vk return tag and committed value
//   valid/rd/dest_from_issuer  rename of rd to a freshly allocated ROB entry
//   dest/rd/value_from_rob     commit of a ROB entry (dest 0 = no commit)
//
// Configuration:
//   REG_FILE_COMMIT_BYPASS_EN  when defined, a commit whose tag matches the read source
//                              is forwarded to that read port in the same cycle.
module reg_file #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                reset_from_rob_bus,
  input  logic [4:0]          rs1_from_issuer,
  input  logic [4:0]          rs2_from_issuer,
  output logic [ROB_ID_W-1:0] qj_to_issuer,
  output logic [XLEN-1:0]     vj_to_issuer,
  output logic [ROB_ID_W-1:0] qk_to_issuer,
  output logic [XLEN-1:0]     vk_to_issuer,
  input  logic                valid_from_issuer,
  input  logic [4:0]          rd_from_issuer,
  input  logic [ROB_ID_W-1:0] dest_from_issuer,
  input  logic [ROB_ID_W-1:0] dest_from_rob,
  input  logic [4:0]          rd_from_rob,
  input  logic [XLEN-1:0]     value_from_rob
);

  localparam int NumRegs = int'(REG_NUM);

  // Entry 0 is deliberately absent: x0 is hardwired to zero.
  logic [XLEN-1:0]     value_q [1:NumRegs-1];
  logic [XLEN-1:0]     value_d [1:NumRegs-1];
  logic [ROB_ID_W-1:0] tag_q   [1:NumRegs-1];
  logic [ROB_ID_W-1:0] tag_d   [1:NumRegs-1];

  logic commit_en;
  logic rename_en;

  assign commit_en = (dest_from_rob != '0) && (rd_from_rob != '0);
  // A flush squashes the rename that arrives alongside it.
  assign rename_en = valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (commit_en) begin
      value_d[rd_from_rob] = value_from_rob;
      // Only the producer that still owns the register may clear its tag;
      // a younger rename keeps its own tag.
      if (tag_q[rd_from_rob] == dest_from_rob) begin
        tag_d[rd_from_rob] = '0;
      end
    end
    // Rename after commit so a same-cycle rename of the same rd wins.
    if (rename_en) begin
      tag_d[rd_from_issuer] = dest_from_issuer;
    end
    if (reset_from_rob_bus) begin
      for (int i = 1; i < NumRegs; i++) begin
        tag_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NumRegs; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  // Read ports: index 0 = rs1 (qj/vj), index 1 = rs2 (qk/vk).
  logic [4:0]          rs_idx [2];
  logic [ROB_ID_W-1:0] rd_q   [2];
  logic [XLEN-1:0]     rd_v   [2];

  assign rs_idx[0] = rs1_from_issuer;
  assign rs_idx[1] = rs2_from_issuer;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_q[p] = '0;
      rd_v[p] = '0;
      if (rs_idx[p] != '0) begin
        rd_q[p] = tag_q[rs_idx[p]];
        rd_v[p] = value_q[rs_idx[p]];
`ifdef REG_FILE_COMMIT_BYPASS_EN
        // Forward a commit that retires exactly the producer this source waits on.
        if (rdy && !rst && (rs_idx[p] == rd_from_rob) && (dest_from_rob != '0) &&
            (tag_q[rs_idx[p]] == dest_from_rob)) begin
          rd_q[p] = '0;
          rd_v[p] = value_from_rob;
        end
`endif
      end
    end
  end

  assign qj_to_issuer = rd_q[0];
  assign vj_to_issuer = rd_v[0];
  assign qk_to_issuer = rd_q[1];
  assign vk_to_issuer = rd_v[1];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. Stimulus pushes expected read results
// (from a behavioural model, plus hand-written constants for the directed cases) into a
// queue tagged with the cycle number; a monitor pops and compares at each negedge.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, reset_from_rob_bus;
  logic [4:0]  rs1_from_issuer, rs2_from_issuer, rd_from_issuer, rd_from_rob;
  logic [3:0]  qj_to_issuer, qk_to_issuer, dest_from_issuer, dest_from_rob;
  logic [31:0] vj_to_issuer, vk_to_issuer, value_from_rob;
  logic        valid_from_issuer;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (reset_from_rob_bus),
    .rs1_from_issuer    (rs1_from_issuer),
    .rs2_from_issuer    (rs2_from_issuer),
    .qj_to_issuer       (qj_to_issuer),
    .vj_to_issuer       (vj_to_issuer),
    .qk_to_issuer       (qk_to_issuer),
    .vk_to_issuer       (vk_to_issuer),
    .valid_from_issuer  (valid_from_issuer),
    .rd_from_issuer     (rd_from_issuer),
    .dest_from_issuer   (dest_from_issuer),
    .dest_from_rob      (dest_from_rob),
    .rd_from_rob        (rd_from_rob),
    .value_from_rob     (value_from_rob)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  mask;   // {qj, vj, qk, vk}
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain arrays indexed by register number, x0 kept at zero.
  logic [31:0] mval [32];
  logic [3:0]  mtag [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_idle();
    rst = 1'b0; rdy = 1'b1; reset_from_rob_bus = 1'b0;
    rs1_from_issuer = '0; rs2_from_issuer = '0;
    valid_from_issuer = 1'b0; rd_from_issuer = '0; dest_from_issuer = '0;
    dest_from_rob = '0; rd_from_rob = '0; value_from_rob = '0;
  endtask

  task automatic mread(input logic [4:0] rs, output logic [3:0] q, output logic [31:0] v);
    q = (rs == 0) ? 4'd0 : mtag[rs];
    v = (rs == 0) ? 32'd0 : mval[rs];
`ifdef REG_FILE_COMMIT_BYPASS_EN
    if (rdy && !rst && rs != 0 && rs == rd_from_rob && dest_from_rob != 0 &&
        mtag[rs] == dest_from_rob) begin
      q = 4'd0;
      v = value_from_rob;
    end
`endif
  endtask

  task automatic model_update();
    logic clr;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mval[i] = '0; mtag[i] = '0; end
    end else if (rdy) begin
      clr = 1'b0;
      if (dest_from_rob != 0 && rd_from_rob != 0) begin
        mval[rd_from_rob] = value_from_rob;
        clr = (mtag[rd_from_rob] == dest_from_rob);
      end
      if (reset_from_rob_bus) begin
        for (int i = 0; i < 32; i++) mtag[i] = '0;
      end else begin
        if (clr) mtag[rd_from_rob] = '0;
        if (valid_from_issuer && rd_from_issuer != 0) mtag[rd_from_issuer] = dest_from_issuer;
      end
    end
  endtask

  // Constant expectation for the current cycle (directed cases).
  task automatic expect_now(input string nm, input logic [3:0] mask, input logic [3:0] qj,
                            input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.mask = mask;
    e.qj = qj; e.vj = vj; e.qk = qk; e.vk = vk;
    sbq.push_back(e);
  endtask

  // Push model expectation for the inputs currently driven, then clock once.
  task automatic cycle(input string nm);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.mask = 4'hF;
    mread(rs1_from_issuer, e.qj, e.vj);
    mread(rs2_from_issuer, e.qk, e.vk);
    sbq.push_back(e);
    @(posedge clk);
    model_update();
    #1;
    set_idle();
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s @cyc %0d: got %h required %h", nm, fld, cyc, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        if (e.mask[3]) cmp(e.name, "qj", 32'(qj_to_issuer), 32'(e.qj));
        if (e.mask[2]) cmp(e.name, "vj", vj_to_issuer, e.vj);
        if (e.mask[1]) cmp(e.name, "qk", 32'(qk_to_issuer), 32'(e.qk));
        if (e.mask[0]) cmp(e.name, "vk", vk_to_issuer, e.vk);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mval[i] = 'x; mtag[i] = 'x; end
    set_idle();
    rst = 1'b1;
    @(posedge clk); model_update(); #1;
    @(posedge clk); model_update(); #1;
    set_idle();

    // Reset state.
    rs1_from_issuer = 5; rs2_from_issuer = 0;
    expect_now("reset", 4'hF, 0, 0, 0, 0);
    cycle("reset");

    // Rename x5->3, then commit it.
    valid_from_issuer = 1; rd_from_issuer = 5; dest_from_issuer = 3; rs1_from_issuer = 5;
    cycle("ren5");
    rs1_from_issuer = 5;
    expect_now("ren5_vis", 4'h8, 3, 0, 0, 0);
    dest_from_rob = 3; rd_from_rob = 5; value_from_rob = 32'hDEADBEEF;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    expect_now("com5_byp", 4'hC, 0, 32'hDEADBEEF, 0, 0);
`endif
    cycle("com5");
    rs1_from_issuer = 5;
    expect_now("com5_vis", 4'hC, 0, 32'hDEADBEEF, 0, 0);
    cycle("com5_vis");

    // Younger rename keeps its tag.
    valid_from_issuer = 1; rd_from_issuer = 7; dest_from_issuer = 2; cycle("ren7a");
    valid_from_issuer = 1; rd_from_issuer = 7; dest_from_issuer = 4; cycle("ren7b");
    dest_from_rob = 2; rd_from_rob = 7; value_from_rob = 32'h11; rs1_from_issuer = 7;
    cycle("com7");
    rs1_from_issuer = 7;
    expect_now("tag_kept", 4'hC, 4, 32'h11, 0, 0);
    cycle("tag_kept");

    // Same-cycle commit and rename on x9: rename wins the tag.
    dest_from_rob = 6; rd_from_rob = 9; value_from_rob = 32'h22;
    valid_from_issuer = 1; rd_from_issuer = 9; dest_from_issuer = 8;
    cycle("com_ren9");
    rs2_from_issuer = 9;
    expect_now("ren_wins", 4'h3, 0, 0, 8, 32'h22);
    cycle("ren_wins");

    // Flush with same-cycle commit and rename.
    valid_from_issuer = 1; rd_from_issuer = 1; dest_from_issuer = 10; cycle("ren1");
    valid_from_issuer = 1; rd_from_issuer = 2; dest_from_issuer = 11; cycle("ren2");
    valid_from_issuer = 1; rd_from_issuer = 3; dest_from_issuer = 12; cycle("ren3");
    reset_from_rob_bus = 1; dest_from_rob = 1; rd_from_rob = 1; value_from_rob = 32'h33;
    valid_from_issuer = 1; rd_from_issuer = 3; dest_from_issuer = 5;
    cycle("flush");
    rs1_from_issuer = 1; rs2_from_issuer = 2;
    expect_now("flush12", 4'hE, 0, 32'h33, 0, 0);
    cycle("flush12");
    rs1_from_issuer = 3; rs2_from_issuer = 5;
    expect_now("flush3", 4'hC, 0, 0, 0, 32'hDEADBEEF);
    cycle("flush3");

    // rdy low holds state.
    valid_from_issuer = 1; rd_from_issuer = 4; dest_from_issuer = 7; cycle("ren4");
    rdy = 0; valid_from_issuer = 1; rd_from_issuer = 4; dest_from_issuer = 6; cycle("hold4");
    rs1_from_issuer = 4;
    expect_now("hold4_vis", 4'h8, 7, 0, 0, 0);
    cycle("hold4_vis");

    // Commit forwarding case.
    valid_from_issuer = 1; rd_from_issuer = 10; dest_from_issuer = 9; cycle("ren10");
    rs1_from_issuer = 10; dest_from_rob = 9; rd_from_rob = 10; value_from_rob = 32'h44;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    expect_now("bypass", 4'hC, 0, 32'h44, 0, 0);
`else
    expect_now("no_bypass", 4'h8, 9, 0, 0, 0);
`endif
    cycle("com10");
    rs1_from_issuer = 10;
    expect_now("com10_vis", 4'hC, 0, 32'h44, 0, 0);
    cycle("com10_vis");

    // Randomized traffic; small rd range to force collisions.
    for (int n = 0; n < 2000; n++) begin
      rst                = ($urandom_range(0, 199) == 0);
      rdy                = ($urandom_range(0, 9) != 0);
      reset_from_rob_bus = ($urandom_range(0, 19) == 0);
      rs1_from_issuer    = 5'($urandom_range(0, 31));
      rs2_from_issuer    = 5'($urandom_range(0, 7));
      valid_from_issuer  = $urandom_range(0, 1) == 1;
      rd_from_issuer     = 5'($urandom_range(0, 7));
      dest_from_issuer   = 4'($urandom_range(1, 15));
      dest_from_rob      = 4'($urandom_range(0, 15));
      rd_from_rob        = 5'($urandom_range(0, 7));
      value_from_rob     = $urandom;
      // Steer some reads onto the committing register to hit forwarding.
      if ($urandom_range(0, 3) == 0) rs1_from_issuer = rd_from_rob;
      cycle("rand");
    end

    @(negedge clk);
    #1;
    cmp("sb_drain", "left", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
